// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO unit: register map and 7-segment patterns.
package gpio_pkg;

    localparam logic [10:0] GPIO_BASE    = 11'h400;
    localparam logic [10:0] ADDR_LED     = GPIO_BASE;
    localparam logic [10:0] ADDR_HEX     = GPIO_BASE + 11'd1;
    localparam logic [10:0] ADDR_SW      = GPIO_BASE + 11'd2;
    localparam logic [10:0] ADDR_KEYSTAT = GPIO_BASE + 11'd3;
    localparam logic [10:0] ADDR_KEYEDGE = GPIO_BASE + 11'd4;

    typedef enum logic [10:0] {
        REG_LED     = ADDR_LED,
        REG_HEX     = ADDR_HEX,
        REG_SW      = ADDR_SW,
        REG_KEYSTAT = ADDR_KEYSTAT,
        REG_KEYEDGE = ADDR_KEYEDGE
    } gpio_reg_e;

    localparam int unsigned HEX_DIGITS = 6;
    localparam int unsigned HEX_W      = 4 * HEX_DIGITS;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/gpio_mmio_unit_hex7seg.sv
// Hex nibble to active-low 7-segment pattern.
module hex7seg
    import gpio_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = SEG_LUT[i_nib];

endmodule

// File: rtl/gpio_mmio_unit.sv
// GPIO peripheral on the data-memory bus: LEDs, six 7-segment digits,
// synchronised switches and debounced, edge-captured push-buttons.
module gpio_mmio_unit
    import gpio_pkg::*;
#(
    parameter int unsigned N_LEDS          = 10,
    parameter int unsigned N_SW            = 10,
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [10:0]       address,
    input  logic [31:0]       write_data,
    input  logic              gpio_we,
    input  logic [N_SW-1:0]   sw,
    input  logic [N_KEYS-1:0] key_n,
    output logic [31:0]       read_data_GPIO,
    output logic [N_LEDS-1:0] leds,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_LEDS-1:0] r_led;
    logic [HEX_W-1:0]  r_hex;
    logic [N_SW-1:0]   r_sw_s1, r_sw_s2;
    logic [N_KEYS-1:0] r_key_s1, r_key_s2;
    logic [N_KEYS-1:0] r_key_edge;
    logic [N_KEYS-1:0] w_key_acc;
    logic [N_KEYS-1:0] w_keystat;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_edge_clr;
    logic              w_we_led, w_we_hex, w_we_keyedge;
    logic [6:0]        w_seg [HEX_DIGITS];
    logic              w_unused_wdata;

    // Only GPIO-space addresses decode, so RAM stores never disturb registers
    assign w_we_led     = gpio_we && (address == REG_LED);
    assign w_we_hex     = gpio_we && (address == REG_HEX);
    assign w_we_keyedge = gpio_we && (address == REG_KEYEDGE);
    assign w_edge_clr   = w_we_keyedge ? write_data[N_KEYS-1:0] : '0;
    assign w_unused_wdata = ^write_data[31:HEX_W];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_led      <= '0;
            r_hex      <= '0;
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_key_s1   <= '1;
            r_key_s2   <= '1;
            r_key_edge <= '0;
        end else begin
            if (w_we_led) r_led <= write_data[N_LEDS-1:0];
            if (w_we_hex) r_hex <= write_data[HEX_W-1:0];
            r_sw_s1    <= sw;
            r_sw_s2    <= r_sw_s1;
            r_key_s1   <= key_n;
            r_key_s2   <= r_key_s1;
            // A new press beats a simultaneous write-1-to-clear
            r_key_edge <= (r_key_edge & ~w_edge_clr) | w_press;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic [CNT_W-1:0] r_cnt;
        logic             r_acc;

        // Accept a new level only after it has been stable DEBOUNCE_CYCLES samples
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) begin
                r_cnt <= '0;
                r_acc <= 1'b1;
            end else if (r_key_s2[k] == r_acc) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_acc <= r_key_s2[k];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_key_acc[k] = r_acc;
        assign w_press[k]   = !r_key_s2[k] && r_acc && (r_cnt == CNT_MAX);
    end

    assign w_keystat = ~w_key_acc;
    assign leds      = r_led;

    always_comb begin
        read_data_GPIO = '0;
        case (address)
            REG_LED:     read_data_GPIO = 32'(r_led);
            REG_HEX:     read_data_GPIO = 32'(r_hex);
            REG_SW:      read_data_GPIO = 32'(r_sw_s2);
            REG_KEYSTAT: read_data_GPIO = 32'(w_keystat);
            REG_KEYEDGE: read_data_GPIO = 32'(r_key_edge);
            default:     read_data_GPIO = '0;
        endcase
    end

    for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_hex
        hex7seg u_hex7seg (
            .i_nib   (r_hex[4*i +: 4]),
            .o_seg_c (w_seg[i])
        );
    end

    assign hex0 = w_seg[0];
    assign hex1 = w_seg[1];
    assign hex2 = w_seg[2];
    assign hex3 = w_seg[3];
    assign hex4 = w_seg[4];
    assign hex5 = w_seg[5];

endmodule
